// File: rtl/mem_bus_responder_if.sv
// Single-beat req/ack memory bus between the responder (master) and memory (slave).
interface mem_bus_responder_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_bus_responder.sv
// Serialises core fetch and load/store requests onto a single-beat req/ack memory bus.
// Optional access timeout with sticky bus_err is enabled by defining MEM_TIMEOUT_EN.
module mem_bus_responder #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              instr_read_en,
    input  logic [ADDR_W-1:0] pc,
    input  logic              load_en,
    input  logic              store_en,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] store_data,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [DATA_W-1:0] load_data,
    output logic              data_valid,
    output logic              busy,
    output logic              bus_err,
    mem_bus_responder_if.master bus
);

    typedef enum logic [1:0] {StIdle, StDataWait, StFetchWait} state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] load_data_q, load_data_d;
    logic              instr_valid_q, instr_valid_d;
    logic              data_valid_q, data_valid_d;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            bus_err_q, bus_err_d;
    logic            timeout_hit;

    // Abort on the wait cycle whose missing ack would bring the count to TIMEOUT.
    assign timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign bus_err        = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        instr_d       = instr_q;
        load_data_d   = load_data_q;
        instr_valid_d = 1'b0;
        data_valid_d  = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d         = cnt_q;
        bus_err_d     = bus_err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (store_en || load_en) begin
                    addr_d  = data_addr;
                    wdata_d = store_data;
                    we_d    = store_en;
                    req_d   = 1'b1;
                    state_d = StDataWait;
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else if (instr_read_en) begin
                    addr_d  = pc;
                    we_d    = 1'b0;
                    req_d   = 1'b1;
                    state_d = StFetchWait;
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            StDataWait: begin
                if (bus.mem_ack) begin
                    req_d        = 1'b0;
                    data_valid_d = 1'b1;
                    state_d      = StIdle;
                    if (!we_q) begin
                        load_data_d = bus.mem_rdata;
                    end
`ifdef MEM_TIMEOUT_EN
                end else if (timeout_hit) begin
                    req_d        = 1'b0;
                    data_valid_d = 1'b1;
                    bus_err_d    = 1'b1;
                    state_d      = StIdle;
                    if (!we_q) begin
                        load_data_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            StFetchWait: begin
                if (bus.mem_ack) begin
                    req_d         = 1'b0;
                    instr_d       = bus.mem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = StIdle;
`ifdef MEM_TIMEOUT_EN
                end else if (timeout_hit) begin
                    req_d         = 1'b0;
                    instr_d       = '0;
                    instr_valid_d = 1'b1;
                    bus_err_d     = 1'b1;
                    state_d       = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= StIdle;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            instr_q       <= '0;
            load_data_q   <= '0;
            instr_valid_q <= 1'b0;
            data_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            instr_q       <= instr_d;
            load_data_q   <= load_data_d;
            instr_valid_q <= instr_valid_d;
            data_valid_q  <= data_valid_d;
        end
    end

    assign busy          = (state_q != StIdle);
    assign instr         = instr_q;
    assign load_data     = load_data_q;
    assign instr_valid   = instr_valid_q;
    assign data_valid    = data_valid_q;
    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: vector table, corner-case sequences and random
// transactions checked against a rule-level model. Timeout checks run when MEM_TIMEOUT_EN is set.
module tb_mem_bus_responder;

    logic        clk;
    logic        n_rst;
    logic        instr_read_en;
    logic [31:0] pc;
    logic        load_en;
    logic        store_en;
    logic [31:0] data_addr;
    logic [31:0] store_data;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] load_data;
    logic        data_valid;
    logic        busy;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;

    mem_bus_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_bus_responder #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .instr_read_en (instr_read_en),
        .pc            (pc),
        .load_en       (load_en),
        .store_en      (store_en),
        .data_addr     (data_addr),
        .store_data    (store_data),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .load_data     (load_data),
        .data_valid    (data_valid),
        .busy          (busy),
        .bus_err       (bus_err),
        .bus           (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        se, le, ie;
        logic [31:0] daddr, pcv, sd;
        int          waits;
        logic [31:0] rd;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic        exp_dv, exp_iv;
        logic [31:0] exp_ld, exp_instr;
    } vec_t;

    vec_t vecs[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        instr_read_en = 1'b0;
        load_en       = 1'b0;
        store_en      = 1'b0;
        bus.mem_ack   = 1'b0;
    endtask

    // One complete access: request for one cycle, 'waits' ack-less cycles, then ack.
    task automatic run_access(input string tag, input vec_t v);
        store_en      = v.se;
        load_en       = v.le;
        instr_read_en = v.ie;
        data_addr     = v.daddr;
        pc            = v.pcv;
        store_data    = v.sd;
        step();
        check({tag, " req"}, {31'd0, bus.mem_req}, 32'd1);
        check({tag, " busy"}, {31'd0, busy}, 32'd1);
        check({tag, " addr"}, bus.mem_addr, v.exp_addr);
        check({tag, " we"}, {31'd0, bus.mem_we}, {31'd0, v.exp_we});
        if (v.exp_we) check({tag, " wdata"}, bus.mem_wdata, v.sd);
        store_en      = 1'b0;
        load_en       = 1'b0;
        instr_read_en = 1'b0;
        data_addr     = $urandom;
        pc            = $urandom;
        store_data    = $urandom;
        for (int i = 0; i < v.waits; i++) begin
            step();
            check({tag, " req held"}, {31'd0, bus.mem_req}, 32'd1);
            check({tag, " addr held"}, bus.mem_addr, v.exp_addr);
            check({tag, " no early valid"}, {30'd0, data_valid, instr_valid}, 32'd0);
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = v.rd;
        step();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = $urandom;
        check({tag, " data_valid"}, {31'd0, data_valid}, {31'd0, v.exp_dv});
        check({tag, " instr_valid"}, {31'd0, instr_valid}, {31'd0, v.exp_iv});
        check({tag, " load_data"}, load_data, v.exp_ld);
        check({tag, " instr"}, instr, v.exp_instr);
        check({tag, " req low"}, {31'd0, bus.mem_req}, 32'd0);
        check({tag, " busy low"}, {31'd0, busy}, 32'd0);
        step();
        check({tag, " pulse width"}, {30'd0, data_valid, instr_valid}, 32'd0);
    endtask

    logic [31:0] m_ld, m_instr;
    vec_t        rv;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h100, 32'h0, 3, 32'h00A00093,
                    1'b0, 32'h100, 1'b0, 1'b1, 32'h0, 32'h00A00093};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h2000, 32'h444, 32'h0, 1, 32'hDEADBEEF,
                    1'b0, 32'h2000, 1'b1, 1'b0, 32'hDEADBEEF, 32'h00A00093};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h2004, 32'h0, 32'h12345678, 0, 32'hFFFF0000,
                    1'b1, 32'h2004, 1'b1, 1'b0, 32'hDEADBEEF, 32'h00A00093};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h2008, 32'h500, 32'hCAFEF00D, 2, 32'h11111111,
                    1'b1, 32'h2008, 1'b1, 1'b0, 32'hDEADBEEF, 32'h00A00093};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h104, 32'h0, 0, 32'h00100073,
                    1'b0, 32'h104, 1'b0, 1'b1, 32'hDEADBEEF, 32'h00100073};

        idle_inputs();
        pc            = '0;
        data_addr     = '0;
        store_data    = '0;
        bus.mem_rdata = '0;
        n_rst         = 1'b0;
        repeat (3) step();
        check("reset outputs", {28'd0, bus.mem_req, busy, data_valid, instr_valid}, 32'd0);
        check("reset misc", {30'd0, bus.mem_we, bus_err}, 32'd0);
        check("reset instr", instr, 32'd0);
        check("reset load_data", load_data, 32'd0);
        check("reset mem_addr", bus.mem_addr, 32'd0);
        check("reset mem_wdata", bus.mem_wdata, 32'd0);
        n_rst = 1'b1;
        step();

        for (int i = 0; i < 5; i++) run_access($sformatf("vec%0d", i), vecs[i]);

        // Ack in idle must be ignored.
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h55555555;
        step();
        bus.mem_ack = 1'b0;
        check("idle ack busy", {31'd0, busy}, 32'd0);
        check("idle ack valids", {30'd0, data_valid, instr_valid}, 32'd0);
        check("idle ack load_data", load_data, 32'hDEADBEEF);

        // Held fetch enable: second request starts right after the first valid pulse.
        instr_read_en = 1'b1;
        pc            = 32'h300;
        step();
        check("b2b first req", {31'd0, bus.mem_req}, 32'd1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hAAAA0001;
        step();
        bus.mem_ack = 1'b0;
        check("b2b first valid", {31'd0, instr_valid}, 32'd1);
        check("b2b first req low", {31'd0, bus.mem_req}, 32'd0);
        step();
        check("b2b second req", {31'd0, bus.mem_req}, 32'd1);
        check("b2b valid dropped", {31'd0, instr_valid}, 32'd0);
        instr_read_en = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hAAAA0002;
        step();
        bus.mem_ack = 1'b0;
        check("b2b second instr", instr, 32'hAAAA0002);
        step();

        // Asynchronous reset in the middle of a load.
        load_en   = 1'b1;
        data_addr = 32'h4000;
        step();
        load_en = 1'b0;
        step();
        n_rst = 1'b0;
        #1;
        check("rst mid req/busy/valid",
              {28'd0, bus.mem_req, busy, data_valid, instr_valid}, 32'd0);
        check("rst mid instr", instr, 32'd0);
        step();
        n_rst         = 1'b1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h77777777;
        step();
        bus.mem_ack = 1'b0;
        step();
        check("rst after release", {28'd0, bus.mem_req, busy, data_valid, instr_valid}, 32'd0);
        check("rst after load_data", load_data, 32'd0);

`ifdef MEM_TIMEOUT_EN
        load_en   = 1'b1;
        data_addr = 32'h6000;
        step();
        load_en = 1'b0;
        repeat (14) begin
            step();
            check("timeout req held", {31'd0, bus.mem_req}, 32'd1);
        end
        step();
        check("timeout req low", {31'd0, bus.mem_req}, 32'd0);
        check("timeout bus_err", {31'd0, bus_err}, 32'd1);
        check("timeout data_valid", {31'd0, data_valid}, 32'd1);
        check("timeout load_data", load_data, 32'd0);
        step();
        run_access("post-timeout store", '{1'b1, 1'b0, 1'b0, 32'h6004, 32'h0, 32'h0BADF00D, 1,
                   32'h0, 1'b1, 32'h6004, 1'b1, 1'b0, 32'h0, 32'h0});
        check("bus_err sticky", {31'd0, bus_err}, 32'd1);
`else
        check("bus_err tied low", {31'd0, bus_err}, 32'd0);
`endif

        // Random transactions against the priority/hold rules.
        m_ld    = 32'd0;
        m_instr = 32'd0;
        for (int t = 0; t < 40; t++) begin
            rv.se    = 1'($urandom_range(0, 1));
            rv.le    = 1'($urandom_range(0, 1));
            rv.ie    = 1'($urandom_range(0, 1));
            rv.daddr = $urandom;
            rv.pcv   = $urandom;
            rv.sd    = $urandom;
            rv.waits = $urandom_range(0, 4);
            rv.rd    = $urandom;
            if (!(rv.se || rv.le || rv.ie)) begin
                step();
                check($sformatf("rnd%0d idle busy", t), {31'd0, busy}, 32'd0);
                continue;
            end
            if (rv.se || rv.le) begin
                rv.exp_addr = rv.daddr;
                if (!rv.se) m_ld = rv.rd;
            end else begin
                rv.exp_addr = rv.pcv;
                m_instr = rv.rd;
            end
            rv.exp_we    = rv.se;
            rv.exp_dv    = rv.se || rv.le;
            rv.exp_iv    = !(rv.se || rv.le);
            rv.exp_ld    = m_ld;
            rv.exp_instr = m_instr;
            run_access($sformatf("rnd%0d", t), rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Memory-side partner of the core's fetch/load-store stall controller.
- Takes instruction-fetch requests (instr_read_en + pc) and data requests (load_en/store_en + address/data) from the core.
- Runs one single-beat access at a time on a req/ack memory bus and returns fetched instructions or load data with one-cycle valid pulses.
- Drives busy so the core stays halted while an access is outstanding.

Parameters:
- ADDR_W, 32, width of pc, data_addr and mem_addr.
- DATA_W, 32, width of the instruction, load, store and memory data paths.
- TIMEOUT, 15, maximum DATA_WAIT/FETCH_WAIT cycles with mem_ack low before the access is aborted (only with MEM_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, all state on rising edge.
- n_rst  input  1  asynchronous active-low reset.
- instr_read_en  input  1  core requests an instruction fetch at pc.
- pc  input  ADDR_W  fetch address.
- load_en  input  1  core requests a data read.
- store_en  input  1  core requests a data write.
- data_addr  input  ADDR_W  load/store address.
- store_data  input  DATA_W  store write data.
- instr  output  DATA_W  last fetched instruction, held until next fetch completes.
- instr_valid  output  1  one-cycle pulse, instr updated.
- load_data  output  DATA_W  last load result, held until next load completes.
- data_valid  output  1  one-cycle pulse, load or store completed.
- busy  output  1  high whenever state != IDLE.
- bus_err  output  1  sticky timeout flag.
- mem_req  output  1  bus request, held until ack.
- mem_we  output  1  1 = write, 0 = read.
- mem_addr  output  ADDR_W  bus address.
- mem_wdata  output  DATA_W  bus write data.
- mem_rdata  input  DATA_W  bus read data, sampled with mem_ack.
- mem_ack  input  1  bus completion, single cycle.

Behaviour:
- Reset (async, n_rst low): state=IDLE, timeout counter=0, and every output 0 (instr, load_data, mem_addr and mem_wdata included). Reset mid-access abandons the access and issues no valid pulse.
- States: IDLE, DATA_WAIT, FETCH_WAIT. All outputs are registered except busy, which is decoded from state.
- IDLE:
  - Priority: store_en, then load_en, then instr_read_en.
  - Data request: latch data_addr into mem_addr, store_data into mem_wdata, mem_we=store_en; set mem_req=1; go DATA_WAIT.
  - Fetch request: latch pc into mem_addr, mem_we=0, mem_req=1; go FETCH_WAIT.
  - load_en and store_en both high: treat as store.
  - mem_ack while IDLE: ignored.
- DATA_WAIT / FETCH_WAIT:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable. Request inputs are ignored.
  - On mem_ack: mem_req=0; return to IDLE.
  - DATA_WAIT ack: data_valid=1 for one cycle. For loads only, load_data<=mem_rdata; stores leave load_data unchanged.
  - FETCH_WAIT ack: instr<=mem_rdata; instr_valid=1 for one cycle.
- Timing:
  - Request seen in IDLE at cycle N: mem_req high from N+1 and busy high from N+1.
  - mem_ack at cycle M: valid pulse, mem_req low and busy low at M+1.
  - The earliest ack is the first cycle mem_req is high, giving a minimum 2-cycle access.
  - A request present at M+1 is accepted at M+1. There are no idle bubbles.
- Held enables: any enable still high in IDLE starts a new access. The core must drop enables after a valid pulse.
- Timeout counter (MEM_TIMEOUT_EN only):
  - Clears on entry to a wait state and increments each wait cycle with mem_ack low.
  - When it reaches TIMEOUT: mem_req=0, bus_err=1 (sticky until reset), and the matching valid pulse is issued with load_data/instr=0; go IDLE.
  - An ack in the same cycle the counter reaches TIMEOUT counts as a normal completion.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined: timeout counter and bus_err behaviour exactly as above.
- Undefined: the counter is absent, wait states last indefinitely until mem_ack, and bus_err is tied 0.

Test Plan:
- Fetch: instr_read_en=1, pc=0x100; ack 3 cycles after mem_req rises with rdata=0x00A00093 -> mem_addr=0x100, mem_we=0, instr=0x00A00093, instr_valid pulses once, busy low next cycle.
- Load priority: load_en=1 addr=0x2000 with instr_read_en=1 in the same cycle -> DATA_WAIT with mem_we=0, mem_addr=0x2000; ack with rdata=0xDEADBEEF -> load_data=0xDEADBEEF, data_valid pulse, instr unchanged, instr_valid stays low.
- Store: store_en=1 addr=0x2004 data=0x12345678, zero-wait ack -> mem_we=1, mem_wdata=0x12345678, data_valid at cycle N+2, load_data unchanged.
- Back-to-back: hold instr_read_en through an ack -> second mem_req rises the cycle after the first valid pulse, with no gap cycle.
- Reset mid-access: n_rst low during DATA_WAIT -> mem_req, busy and valids 0 immediately; after release, stays IDLE with no valid pulse.
- Timeout (MEM_TIMEOUT_EN, TIMEOUT=15): load with no ack -> mem_req drops after 15 wait cycles, bus_err=1 and stays 1, data_valid pulse with load_data=0; a following store with ack completes normally with bus_err still 1.
